ex_mem_pipe_stage: RTL and testbench

//  Parametrised EX->MEM pipeline stage register for the MIPS pipeline.
//  - Carries ALU result, store data, PC, zero flag, WB/M control and destination register.
//  - Adds valid/ready flow control, a 2-entry skid buffer (full throughput under back-pressure),

---
 rtl/mips_pipe_pkg.sv | 34 +++
 rtl/ex_mem_pipe_stage_if.sv | 30 +++
 rtl/pipe_skid_buf.sv | 79 +++++++
 rtl/ex_mem_pipe_stage.sv | 74 +++++++
 tb/tb_ex_mem_pipe_stage.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared widths, skid-buffer state encoding and payload layout for the MIPS
// pipeline stage registers.
package mips_pipe_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_WB_W    = 2;
  localparam int DEF_M_W     = 3;
  localparam int DEF_RADDR_W = 5;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Field order matches the packed payload vector, MSB first.
  typedef struct packed {
    logic                   zero;
    logic [DEF_WB_W-1:0]    wb;
    logic [DEF_M_W-1:0]     m;
    logic [DEF_RADDR_W-1:0] dest;
    logic [DEF_DATA_W-1:0]  alu_res;
    logic [DEF_DATA_W-1:0]  store_data;
    logic [DEF_DATA_W-1:0]  pc;
  } ex_mem_payload_t;

  localparam int PAYLOAD_W = $bits(ex_mem_payload_t);

  function automatic int payload_w(int data_w, int wb_w, int m_w, int raddr_w);
    return 1 + wb_w + m_w + raddr_w + 3 * data_w;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_stage_if.sv
// One valid/ready beat of EX->MEM payload; master drives valid and payload,
// slave drives ready.
interface ex_mem_pipe_stage_if
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WB_W    = DEF_WB_W,
  parameter int M_W     = DEF_M_W,
  parameter int RADDR_W = DEF_RADDR_W
);
  logic               valid;
  logic               ready;
  logic               zero;
  logic [WB_W-1:0]    wb;
  logic [M_W-1:0]     m;
  logic [RADDR_W-1:0] dest;
  logic [DATA_W-1:0]  alu_res;
  logic [DATA_W-1:0]  store_data;
  logic [DATA_W-1:0]  pc;

  modport master (
    output valid, zero, wb, m, dest, alu_res, store_data, pc,
    input  ready
  );

  modport slave (
    input  valid, zero, wb, m, dest, alu_res, store_data, pc,
    output ready
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush. in_ready is
// decoded from the state register only, so it never depends on out_ready.
module pipe_skid_buf
  import mips_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_reg, state_next;
  logic [W-1:0] main_reg, main_next;
  logic [W-1:0] skid_reg, skid_next;
  logic         accept;
  logic         send;

  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign accept    = in_valid & in_ready;
  assign send      = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

  // Flush only empties the buffer; stored data is left untouched.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            main_next  = in_data;
          end
        end
        ONE: begin
          if (send && !accept) begin
            state_next = EMPTY;
          end else if (send && accept) begin
            main_next = in_data;
          end else if (!send && accept) begin
            state_next = FULL;
            skid_next  = in_data;
          end
        end
        FULL: begin
          if (send) begin
            state_next = ONE;
            main_next  = skid_reg;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register: packs the execute-stage beat through a skid
// buffer, masks control fields on bubbles and counts back-pressure cycles.
module ex_mem_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WB_W    = DEF_WB_W,
  parameter int M_W     = DEF_M_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             cnt_clr,
  ex_mem_pipe_stage_if.slave  ex,
  ex_mem_pipe_stage_if.master mem,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PAY_W = payload_w(DATA_W, WB_W, M_W, RADDR_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAY_W-1:0]   in_pay;
  logic [PAY_W-1:0]   out_pay;
  logic               out_valid;
  logic               zero_w;
  logic [WB_W-1:0]    wb_w;
  logic [M_W-1:0]     m_w;
  logic [RADDR_W-1:0] dest_w;
  logic [DATA_W-1:0]  alu_w;
  logic [DATA_W-1:0]  sd_w;
  logic [DATA_W-1:0]  pc_w;
  logic [CNT_W-1:0]   stall_cnt_reg;

  assign in_pay = {ex.zero, ex.wb, ex.m, ex.dest, ex.alu_res, ex.store_data, ex.pc};

  pipe_skid_buf #(.W(PAY_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (ex.valid),
    .in_ready  (ex.ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (mem.ready),
    .out_data  (out_pay)
  );

  assign {zero_w, wb_w, m_w, dest_w, alu_w, sd_w, pc_w} = out_pay;

  // A bubble must never write memory or the register file.
  assign mem.valid      = out_valid;
  assign mem.zero       = zero_w;
  assign mem.wb         = out_valid ? wb_w : '0;
  assign mem.m          = out_valid ? m_w  : '0;
  assign mem.dest       = dest_w;
  assign mem.alu_res    = alu_w;
  assign mem.store_data = sd_w;
  assign mem.pc         = pc_w;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (cnt_clr) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !mem.ready && stall_cnt_reg != CNT_MAX) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Randomised bench for ex_mem_pipe_stage against a queue-based model of the
// stage (at most two beats in flight, head shown on the outputs).
module tb_ex_mem_pipe_stage;
  import mips_pipe_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  typedef struct packed {
    logic        zero;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] pc;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             cnt_clr;
  logic [CNT_W-1:0] stall_cnt;

  ex_mem_pipe_stage_if ex_if ();
  ex_mem_pipe_stage_if mem_if ();

  ex_mem_pipe_stage #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .ex        (ex_if),
    .mem       (mem_if),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t q[$];
  beat_t disp;
  int    cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t rand_beat();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return beat_t'(r[$bits(beat_t)-1:0]);
  endfunction

  task automatic drive(input logic iv, input beat_t b);
    ex_if.valid      = iv;
    ex_if.zero       = b.zero;
    ex_if.wb         = b.wb;
    ex_if.m          = b.m;
    ex_if.dest       = b.dest;
    ex_if.alu_res    = b.alu;
    ex_if.store_data = b.sd;
    ex_if.pc         = b.pc;
  endtask

  task automatic compare_all();
    logic mv;
    mv = (q.size() > 0);
    check("out_valid",  64'(mem_if.valid),      64'(mv));
    check("in_ready",   64'(ex_if.ready),       64'(q.size() < 2));
    check("zero_out",   64'(mem_if.zero),       64'(disp.zero));
    check("wb_out",     64'(mem_if.wb),         mv ? 64'(disp.wb) : 64'd0);
    check("m_out",      64'(mem_if.m),          mv ? 64'(disp.m)  : 64'd0);
    check("dest_out",   64'(mem_if.dest),       64'(disp.dest));
    check("alu_out",    64'(mem_if.alu_res),    64'(disp.alu));
    check("sdata_out",  64'(mem_if.store_data), 64'(disp.sd));
    check("pc_out",     64'(mem_if.pc),         64'(disp.pc));
    check("stall_cnt",  64'(stall_cnt),         64'(cnt));
  endtask

  // One clock: apply inputs, advance the model across the edge, compare.
  task automatic step(input logic iv, input logic ordy, input logic fl,
                      input logic clr, input beat_t b);
    logic m_ready, m_valid;
    drive(iv, b);
    mem_if.ready = ordy;
    flush        = fl;
    cnt_clr      = clr;
    m_ready = (q.size() < 2);
    m_valid = (q.size() > 0);
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (m_valid && ordy) void'(q.pop_front());
      if (iv && m_ready) q.push_back(b);
    end
    if (clr) cnt = 0;
    else if (m_valid && !ordy && cnt != CNT_MAX) cnt++;
    if (q.size() > 0) disp = q[0];
    compare_all();
  endtask

  task automatic async_reset();
    drive(1'b1, rand_beat());
    mem_if.ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    disp = '0;
    cnt  = 0;
    compare_all();
    @(negedge clk);
    ex_if.valid = 1'b0;
    flush       = 1'b0;
    cnt_clr     = 1'b0;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    beat_t b;
    rst   = 1'b0;
    flush = 1'b0;
    cnt_clr = 1'b0;
    b = rand_beat();
    b.alu = 32'hdead_beef;
    drive(1'b1, b);
    mem_if.ready = 1'b1;
    disp = '0;
    cnt  = 0;
    #1;
    compare_all();
    ex_if.valid = 1'b0;
    #7;
    rst = 1'b1;
    @(posedge clk);
    #1;
    compare_all();

    // Back-to-back stream.
    for (int k = 1; k <= 4; k++) begin
      b = rand_beat();
      b.alu = 32'(k);
      step(1'b1, 1'b1, 1'b0, 1'b0, b);
      check("stream_alu", 64'(mem_if.alu_res), 64'(k));
      check("stream_rdy", 64'(ex_if.ready), 64'd1);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, rand_beat());

    // Back-pressure into the skid entry.
    b = rand_beat(); b.alu = 32'hA;
    step(1'b1, 1'b1, 1'b0, 1'b0, b);
    b = rand_beat(); b.alu = 32'hB;
    step(1'b1, 1'b0, 1'b0, 1'b0, b);
    check("bp_rdy_low", 64'(ex_if.ready), 64'd0);
    check("bp_hold_a",  64'(mem_if.alu_res), 64'hA);
    step(1'b0, 1'b1, 1'b0, 1'b0, rand_beat());
    check("bp_out_b",   64'(mem_if.alu_res), 64'hB);
    step(1'b0, 1'b1, 1'b0, 1'b0, rand_beat());
    check("bp_stall1",  64'(stall_cnt), 64'd1);

    // Flush while FULL, with a store offered in the same cycle.
    step(1'b1, 1'b0, 1'b0, 1'b0, rand_beat());
    step(1'b1, 1'b0, 1'b0, 1'b0, rand_beat());
    b = rand_beat(); b.m = 3'b010;
    step(1'b1, 1'b0, 1'b1, 1'b0, b);
    check("fl_valid", 64'(mem_if.valid), 64'd0);
    check("fl_m",     64'(mem_if.m),     64'd0);
    check("fl_wb",    64'(mem_if.wb),    64'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, rand_beat());
      check("fl_quiet", 64'(mem_if.valid), 64'd0);
    end

    // Counter saturation and clear.
    step(1'b1, 1'b1, 1'b0, 1'b1, rand_beat());
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 1'b0, rand_beat());
    check("sat_15", 64'(stall_cnt), 64'd15);
    step(1'b0, 1'b0, 1'b0, 1'b1, rand_beat());
    check("sat_clr", 64'(stall_cnt), 64'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, rand_beat());

    // Random traffic with a mid-run asynchronous reset.
    for (int i = 0; i < 600; i++) begin
      logic iv, ordy, fl, clr;
      if (i == 300) async_reset();
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 31) == 0);
      clr  = ($urandom_range(0, 63) == 0);
      step(iv, ordy, fl, clr, rand_beat());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
